aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys consumed by the addroundkey stage.
- Accepts the key as four 32-bit words and computes one round key per clock.
- Stores all 11 round keys in an internal bank, so the round controller can read any round in either order (encode ascending, decode descending).
- Sits directly upstream of addroundkey and drives its rk0..rk3 inputs.

---
 rtl/aes_key_expand_if.sv | 33 +++
 rtl/aes_key_expand.sv | 155 +++++++++++++++
 tb/tb_aes_key_expand.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand_if
//  Description : Key-load request, round-key read port and status of the
//                AES-128 key expander.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expand_if;
    logic        start;
    logic [31:0] key0;
    logic [31:0] key1;
    logic [31:0] key2;
    logic [31:0] key3;
    logic [3:0]  rd_round;
    logic        busy;
    logic        done;
    logic        key_valid;
    logic [31:0] rk0;
    logic [31:0] rk1;
    logic [31:0] rk2;
    logic [31:0] rk3;

    modport master (
        output start, key0, key1, key2, key3, rd_round,
        input  busy, done, key_valid, rk0, rk1, rk2, rk3
    );

    modport slave (
        input  start, key0, key1, key2, key3, rd_round,
        output busy, done, key_valid, rk0, rk1, rk2, rk3
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expand
//  Description : Iterative AES-128 key schedule, one round key per clock,
//                all round keys held in a bank with a registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expand #(
    parameter int NROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_key_expand_if.slave  bus
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_expand = 2'd1;
    localparam logic [1:0] c_ready  = 2'd2;

    localparam logic [3:0] c_last = 4'(NROUNDS);

    localparam logic [7:0] c_sbox [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {c_sbox[w[31:24]], c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]]};
    endfunction

    logic [1:0]   r_state;
    logic [3:0]   r_cnt;
    logic [7:0]   r_rcon;
    logic [31:0]  r_w0, r_w1, r_w2, r_w3;
    logic         r_busy;
    logic         r_done;
    logic         r_key_valid;
    logic [127:0] r_rk;
    logic [127:0] r_bank [0:NROUNDS];

    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rcon_next;
    logic         w_load;
    logic         w_we;
    logic [3:0]   w_waddr;
    logic [127:0] w_wdata;

    assign w_t  = sub_word({r_w3[23:0], r_w3[31:24]}) ^ {r_rcon, 24'h000000};
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = r_w1 ^ w_n0;
    assign w_n2 = r_w2 ^ w_n1;
    assign w_n3 = r_w3 ^ w_n2;

    // xtime: multiply by x in GF(2^8) modulo the AES polynomial
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    // A start while expanding is dropped, so loads only happen from IDLE/READY
    assign w_load  = bus.start && (r_state != c_expand);
    assign w_we    = w_load || (r_state == c_expand);
    assign w_waddr = w_load ? 4'd0 : r_cnt;
    assign w_wdata = w_load ? {bus.key0, bus.key1, bus.key2, bus.key3}
                            : {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_bank[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_cnt       <= 4'd0;
            r_rcon      <= 8'h01;
            r_w0        <= 32'h0;
            r_w1        <= 32'h0;
            r_w2        <= 32'h0;
            r_w3        <= 32'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle, c_ready: begin
                    if (bus.start) begin
                        r_w0        <= bus.key0;
                        r_w1        <= bus.key1;
                        r_w2        <= bus.key2;
                        r_w3        <= bus.key3;
                        r_cnt       <= 4'd1;
                        r_rcon      <= 8'h01;
                        r_state     <= c_expand;
                        r_busy      <= 1'b1;
                        r_key_valid <= 1'b0;
                    end
                end
                c_expand: begin
                    r_w0   <= w_n0;
                    r_w1   <= w_n1;
                    r_w2   <= w_n2;
                    r_w3   <= w_n3;
                    r_cnt  <= r_cnt + 4'd1;
                    r_rcon <= w_rcon_next;
                    if (r_cnt == c_last) begin
                        r_state     <= c_ready;
                        r_busy      <= 1'b0;
                        r_key_valid <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read sees the bank before any same-edge write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk <= 128'h0;
        end else if (bus.rd_round <= c_last) begin
            r_rk <= r_bank[bus.rd_round];
        end else begin
            r_rk <= 128'h0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.key_valid = r_key_valid;
    assign bus.rk0       = r_rk[127:96];
    assign bus.rk1       = r_rk[95:64];
    assign bus.rk2       = r_rk[63:32];
    assign bus.rk3       = r_rk[31:0];

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expand
//  Description : Self-checking bench for aes_key_expand against a GF(2^8)
//                derived AES-128 key schedule model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if bus();

    aes_key_expand #(.NROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_zero_r1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // ---------------- reference model: S-box from field inverse + affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] p = a;
        int e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, p);
            p = gmul(p, p);
            e = e / 2;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] v = x;
        for (int k = 0; k < n; k++) v = {v[6:0], v[7]};
        return v;
    endfunction

    task automatic build_sbox();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = ginv(8'(i));
            sb[i] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [7:0]  rc;
        logic [31:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rk_now();
        return {bus.rk0, bus.rk1, bus.rk2, bus.rk3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_key(input logic [127:0] k);
        bus.key0 = k[127:96];
        bus.key1 = k[95:64];
        bus.key2 = k[63:32];
        bus.key3 = k[31:0];
    endtask

    // Starts an expansion, optionally re-pulses start (zero key) before edge T+inject_at
    task automatic expand_key(input string tag, input logic [127:0] k, input int inject_at);
        drive_key(k);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, " busy@T"}, {127'b0, bus.busy}, 128'd1);
        chk({tag, " kv@T"}, {127'b0, bus.key_valid}, 128'd0);
        for (int i = 1; i <= 10; i++) begin
            if (i == inject_at) begin
                drive_key(128'h0);
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (i < 10) begin
                chk($sformatf("%s busy@T+%0d", tag, i), {127'b0, bus.busy}, 128'd1);
                chk($sformatf("%s done@T+%0d", tag, i), {127'b0, bus.done}, 128'd0);
            end else begin
                chk({tag, " busy@T+10"}, {127'b0, bus.busy}, 128'd0);
                chk({tag, " done@T+10"}, {127'b0, bus.done}, 128'd1);
                chk({tag, " kv@T+10"}, {127'b0, bus.key_valid}, 128'd1);
            end
        end
        tick();
        chk({tag, " done@T+11"}, {127'b0, bus.done}, 128'd0);
    endtask

    task automatic read_round(input logic [3:0] r, output logic [127:0] v);
        bus.rd_round = r;
        tick();
        v = rk_now();
    endtask

    task automatic sweep_desc(input string tag);
        bus.rd_round = 4'd10;
        for (int r = 10; r >= 0; r--) begin
            tick();
            chk($sformatf("%s rd%0d", tag, r), rk_now(), exp_rk[r]);
            if (r > 0) bus.rd_round = 4'(r - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        logic [127:0] k;
        logic [3:0]   r;

        build_sbox();
        bus.start    = 1'b0;
        bus.rd_round = 4'd0;
        drive_key(128'h0);

        // reset
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", {127'b0, bus.busy}, 128'd0);
        chk("rst done", {127'b0, bus.done}, 128'd0);
        chk("rst kv", {127'b0, bus.key_valid}, 128'd0);
        chk("rst rk", rk_now(), 128'h0);
        rst = 1'b0;
        tick();
        chk("idle kv", {127'b0, bus.key_valid}, 128'd0);

        // 1-3: FIPS-197 key
        model_expand(c_fips_key);
        expand_key("fips", c_fips_key, 0);
        read_round(4'd0, v);  chk("fips r0 const", v, c_fips_key);
        read_round(4'd1, v);  chk("fips r1 const", v, c_fips_r1);
        read_round(4'd10, v); chk("fips r10 const", v, c_fips_r10);
        sweep_desc("fips desc");
        read_round(4'd11, v); chk("rd11 zero", v, 128'h0);
        read_round(4'd15, v); chk("rd15 zero", v, 128'h0);

        // 4: start during EXPAND cycle 4 is ignored
        expand_key("ignore", c_fips_key, 4);
        read_round(4'd10, v); chk("ignore r10 const", v, c_fips_r10);
        sweep_desc("ignore desc");

        // 5: restart from READY with all-zero key
        model_expand(128'h0);
        expand_key("zero", 128'h0, 0);
        read_round(4'd1, v);  chk("zero r1 const", v, c_zero_r1);
        read_round(4'd10, v); chk("zero r10 const", v, c_zero_r10);
        sweep_desc("zero desc");

        // random keys, random read order including out-of-range indices
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            expand_key($sformatf("rand%0d", n), k, 0);
            for (int j = 0; j < 16; j++) begin
                r = 4'($urandom_range(0, 15));
                read_round(r, v);
                chk($sformatf("rand%0d rd%0d", n, r), v, (r <= 4'd10) ? exp_rk[r] : 128'h0);
            end
        end

        // 6: asynchronous reset mid-expansion
        bus.rd_round = 4'd0;
        drive_key(c_fips_key);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("pre-rst rk", rk_now(), c_fips_key);
        #2 rst = 1'b1;
        #1;
        chk("async busy", {127'b0, bus.busy}, 128'd0);
        chk("async done", {127'b0, bus.done}, 128'd0);
        chk("async kv", {127'b0, bus.key_valid}, 128'd0);
        chk("async rk", rk_now(), 128'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("post-rst done%0d", i), {127'b0, bus.done}, 128'd0);
            chk($sformatf("post-rst kv%0d", i), {127'b0, bus.key_valid}, 128'd0);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        expand_key("after-rst", k, 0);
        sweep_desc("after-rst desc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
